// File: rtl/cypher_pkg.sv
// Shared types and helpers for the cypher matcher: FSM state encoding,
// default parameter values, and per-digit extraction from a packed cypher.
package cypher_pkg;

  typedef enum logic [1:0] {
    FILL,
    SCAN,
    LOCKED
  } state_t;

  localparam int unsigned DEF_DIGIT_W    = 4;
  localparam int unsigned DEF_NUM_DIGITS = 4;
  localparam int unsigned DEF_SUM_W      = 8;

  // Upper bounds on the widths the extraction helper can handle.
  localparam int unsigned MAX_DIGIT_W  = 32;
  localparam int unsigned MAX_CYPHER_W = 1024;

  // Digit idx lives at bits [idx*digit_w +: digit_w] of the packed cypher.
  function automatic logic [MAX_DIGIT_W-1:0] cypher_digit(
    input logic [MAX_CYPHER_W-1:0] cypher,
    input int unsigned             idx,
    input int unsigned             digit_w
  );
    logic [MAX_CYPHER_W-1:0] shifted;
    shifted = cypher >> (idx * digit_w);
    return shifted[MAX_DIGIT_W-1:0] & ((MAX_DIGIT_W'(1) << digit_w) - MAX_DIGIT_W'(1));
  endfunction

endpackage

// File: rtl/cypher_matcher_if.sv
// Digit stream handshake between the entry front end and the cypher matcher.
interface cypher_matcher_if import cypher_pkg::*; #(
  parameter int unsigned DIGIT_W = DEF_DIGIT_W
) ();

  logic               in_valid;
  logic [DIGIT_W-1:0] in_digit;
  logic               in_ready;

  modport master (output in_valid, output in_digit, input  in_ready);
  modport slave  (input  in_valid, input  in_digit, output in_ready);

endinterface

// File: rtl/cypher_matcher_digit_window.sv
// Sliding window of the last NUM_DIGITS accepted digits plus a slot-wise
// comparison of the window as it will look after the next shift.
module digit_window import cypher_pkg::*; #(
  parameter int unsigned DIGIT_W    = DEF_DIGIT_W,
  parameter int unsigned NUM_DIGITS = DEF_NUM_DIGITS
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          shift_en,
  input  logic [DIGIT_W-1:0]            digit_in,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] cypher,
  output logic                          next_window_match
);

  localparam int unsigned WIN_W = DIGIT_W * NUM_DIGITS;

  // Slot 0 (lowest bits) is the oldest digit; the newest enters at the top.
  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] win_d;

  always_comb begin
    win_d = WIN_W'({digit_in, win_q} >> DIGIT_W);
    next_window_match = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (win_d[i*DIGIT_W +: DIGIT_W] !=
          DIGIT_W'(cypher_digit(MAX_CYPHER_W'(cypher), i, DIGIT_W))) begin
        next_window_match = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      win_q <= '0;
    end else if (clear) begin
      win_q <= '0;
    end else if (shift_en) begin
      win_q <= win_d;
    end
  end

endmodule

// File: rtl/cypher_matcher.sv
// Cypher detector: digit window compare with fill qualifier, saturating
// running sum, and a control FSM that locks after a match until cleared.
module cypher_matcher import cypher_pkg::*; #(
  parameter  int unsigned DIGIT_W    = DEF_DIGIT_W,
  parameter  int unsigned NUM_DIGITS = DEF_NUM_DIGITS,
  parameter  int unsigned SUM_W      = DEF_SUM_W,
  localparam int unsigned CNT_W      = $clog2(NUM_DIGITS + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          cypher_load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] cypher_in,
  cypher_matcher_if.slave               digit_bus,
  output logic                          match,
  output logic                          locked,
  output logic [SUM_W-1:0]              sum,
  output logic                          sum_sat,
  output logic [CNT_W-1:0]              digit_count
);

  localparam logic [SUM_W:0] SUM_MAX = {1'b0, {SUM_W{1'b1}}};

  state_t                        state;
  state_t                        state_n;
  logic [DIGIT_W*NUM_DIGITS-1:0] cypher_q;
  logic                          accept;
  logic                          window_match;
  logic                          fill_done;
  logic                          go_lock;
  logic [CNT_W-1:0]              count_inc;
  logic [SUM_W:0]                sum_ext;

  assign digit_bus.in_ready = (state != LOCKED) && !clear;
  assign accept             = digit_bus.in_valid && digit_bus.in_ready;
  assign locked             = (state == LOCKED);
  assign count_inc          = digit_count + 1'b1;
  assign fill_done          = (count_inc == CNT_W'(NUM_DIGITS));
  assign sum_ext            = {1'b0, sum} + {{(SUM_W + 1 - DIGIT_W){1'b0}}, digit_bus.in_digit};

  digit_window #(
    .DIGIT_W    (DIGIT_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_window (
    .clock             (clock),
    .reset             (reset),
    .clear             (clear),
    .shift_en          (accept),
    .digit_in          (digit_bus.in_digit),
    .cypher            (cypher_q),
    .next_window_match (window_match)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= FILL;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    go_lock = 1'b0;
    case (state)
      FILL: begin
        if (accept && fill_done) begin
          if (window_match) begin
            go_lock = 1'b1;
            state_n = LOCKED;
          end else begin
            state_n = SCAN;
          end
        end
      end
      SCAN: begin
        if (accept && window_match) begin
          go_lock = 1'b1;
          state_n = LOCKED;
        end
      end
      LOCKED: ;
      default: state_n = FILL;
    endcase
    if (clear) begin
      state_n = FILL;
    end
  end

  // Saturation is flagged once the sum reaches its ceiling, and sticks.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum         <= '0;
      sum_sat     <= 1'b0;
      digit_count <= '0;
      match       <= 1'b0;
    end else if (clear) begin
      sum         <= '0;
      sum_sat     <= 1'b0;
      digit_count <= '0;
      match       <= 1'b0;
    end else begin
      match <= go_lock;
      if (accept) begin
        if (sum_ext >= SUM_MAX) begin
          sum     <= '1;
          sum_sat <= 1'b1;
        end else begin
          sum <= sum_ext[SUM_W-1:0];
        end
        if (state == FILL) begin
          digit_count <= count_inc;
        end
      end
    end
  end

  // Cypher survives clear; a load in the accepting cycle only affects later compares.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cypher_q <= '0;
    end else if (cypher_load && (state != LOCKED)) begin
      cypher_q <= cypher_in;
    end
  end

endmodule

// File: tb/tb_cypher_matcher.sv
// Scoreboard bench for cypher_matcher: directed scenarios plus random traffic
// checked against a history-queue reference model.
module tb_cypher_matcher;

  localparam int DW      = 4;
  localparam int ND      = 4;
  localparam int SW      = 8;
  localparam int SUM_MAX = 255;

  logic        clock = 1'b0;
  logic        reset;
  logic        clear;
  logic        cypher_load;
  logic [15:0] cypher_in;
  logic        match;
  logic        locked;
  logic [7:0]  sum;
  logic        sum_sat;
  logic [2:0]  digit_count;

  cypher_matcher_if #(.DIGIT_W(DW)) bus ();

  cypher_matcher #(
    .DIGIT_W    (DW),
    .NUM_DIGITS (ND),
    .SUM_W      (SW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .cypher_load (cypher_load),
    .cypher_in   (cypher_in),
    .digit_bus   (bus),
    .match       (match),
    .locked      (locked),
    .sum         (sum),
    .sum_sat     (sum_sat),
    .digit_count (digit_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit m;
    bit l;
    int s;
    bit sat;
    int c;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   total = 0;
  int   bad   = 0;
  bit   mon_ev;

  // Reference model: digit history since clear, cypher as digit array.
  int hist[$];
  int m_cyp[ND];
  int m_sum;
  int m_cnt;
  bit m_sat;
  bit m_lock;

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic void model_clear();
    hist.delete();
    m_sum  = 0;
    m_cnt  = 0;
    m_sat  = 0;
    m_lock = 0;
  endfunction

  function automatic void model_load(input logic [15:0] c);
    for (int i = 0; i < ND; i++) m_cyp[i] = int'((c >> (DW * i)) & 16'hF);
  endfunction

  function automatic bit model_accept(input int d);
    bit hit;
    hist.push_back(d);
    if (hist.size() > ND) void'(hist.pop_front());
    if (m_sum + d >= SUM_MAX) begin
      m_sum = SUM_MAX;
      m_sat = 1;
    end else begin
      m_sum = m_sum + d;
    end
    if (m_cnt < ND) m_cnt++;
    hit = (hist.size() == ND);
    for (int i = 0; i < ND; i++) if (hit && hist[i] != m_cyp[i]) hit = 0;
    if (hit) m_lock = 1;
    return hit;
  endfunction

  // One cycle of stimulus, entered and left at a falling edge.
  task automatic step(input bit v, input int d, input bit clr, input bit ld, input logic [15:0] c);
    bit   lock_pre;
    exp_t e;
    lock_pre     = m_lock;
    bus.in_valid = v;
    bus.in_digit = 4'(d);
    clear        = clr;
    cypher_load  = ld;
    cypher_in    = c;
    #1;
    chk("in_ready", int'(bus.in_ready), int'(!lock_pre && !clr));
    if (clr) begin
      model_clear();
      e = '{m: 0, l: 0, s: 0, sat: 0, c: 0};
      sb.push_back(e);
    end else if (v && !lock_pre) begin
      e.m   = model_accept(d);
      e.l   = m_lock;
      e.s   = m_sum;
      e.sat = m_sat;
      e.c   = m_cnt;
      sb.push_back(e);
    end
    if (ld && !lock_pre) model_load(c);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 16'h0);
  endtask

  task automatic send4(input int a, input int b, input int c, input int d);
    step(1, a, 0, 0, 16'h0);
    step(1, b, 0, 0, 16'h0);
    step(1, c, 0, 0, 16'h0);
    step(1, d, 0, 0, 16'h0);
  endtask

  // Asynchronous reset asserted between edges; outputs must drop at once.
  task automatic async_reset();
    #2;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    clear        = 1'b0;
    cypher_load  = 1'b0;
    #1;
    chk("rst_match", int'(match), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_sum", int'(sum), 0);
    chk("rst_sat", int'(sum_sat), 0);
    chk("rst_count", int'(digit_count), 0);
    chk("rst_ready", int'(bus.in_ready), 1);
    model_clear();
    model_load(16'h0);
    sb.delete();
    last = '{m: 0, l: 0, s: 0, sat: 0, c: 0};
    @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
  endtask

  // Monitor: pops on every clear/accept edge, otherwise outputs must hold.
  always @(posedge clock) begin
    mon_ev = !reset && (clear || (bus.in_valid && bus.in_ready));
    @(negedge clock);
    if (!reset) begin
      if (mon_ev) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          last = sb.pop_front();
          chk("match", int'(match), int'(last.m));
        end
      end else begin
        chk("match_idle", int'(match), 0);
      end
      chk("locked", int'(locked), int'(last.l));
      chk("sum", int'(sum), last.s);
      chk("sum_sat", int'(sum_sat), int'(last.sat));
      chk("digit_count", int'(digit_count), last.c);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] rc;
    reset        = 1'b1;
    clear        = 1'b0;
    cypher_load  = 1'b0;
    cypher_in    = '0;
    bus.in_valid = 1'b0;
    bus.in_digit = '0;
    model_clear();
    model_load(16'h0);
    last = '{m: 0, l: 0, s: 0, sat: 0, c: 0};
    @(negedge clock);
    chk("init_sum", int'(sum), 0);
    chk("init_locked", int'(locked), 0);
    chk("init_count", int'(digit_count), 0);
    #2 reset = 1'b0;
    @(negedge clock);

    // Basic match, lock behaviour, clear with simultaneous digit, cypher retained.
    step(0, 0, 0, 1, 16'h4321);
    send4(1, 2, 3, 4);
    idle(1);
    step(1, 7, 0, 0, 16'h0);
    step(1, 7, 0, 0, 16'h0);
    step(1, 7, 1, 0, 16'h0);
    send4(1, 2, 3, 4);
    idle(1);

    // All-zero cypher is gated by the fill qualifier.
    async_reset();
    step(1, 0, 0, 0, 16'h0);
    step(1, 0, 0, 0, 16'h0);
    step(1, 0, 0, 0, 16'h0);
    idle(1);
    step(1, 0, 0, 0, 16'h0);
    idle(1);
    step(0, 0, 1, 0, 16'h0);
    send4(0, 0, 0, 5);
    idle(1);

    // Clear together with load, then a sliding-window match on the 5th digit.
    step(0, 0, 1, 1, 16'h4321);
    step(1, 9, 0, 0, 16'h0);
    send4(1, 2, 3, 4);
    idle(1);

    // Accept in the load cycle still compares against the previous cypher.
    step(0, 0, 1, 0, 16'h0);
    step(1, 1, 0, 0, 16'h0);
    step(1, 2, 0, 0, 16'h0);
    step(1, 3, 0, 0, 16'h0);
    step(1, 4, 0, 1, 16'h9999);
    idle(1);

    // Saturation of the running sum.
    step(0, 0, 1, 0, 16'h0);
    step(0, 0, 0, 1, 16'h1234);
    for (int i = 0; i < 16; i++) step(1, 15, 0, 0, 16'h0);
    step(1, 15, 0, 0, 16'h0);
    for (int i = 0; i < 3; i++) step(1, 15, 0, 0, 16'h0);
    idle(1);

    // Reset mid-stream returns the cypher to zero.
    step(0, 0, 1, 1, 16'h4321);
    step(1, 1, 0, 0, 16'h0);
    step(1, 2, 0, 0, 16'h0);
    async_reset();
    send4(1, 2, 3, 4);
    idle(1);

    // Randomised traffic over a small digit alphabet so matches occur.
    for (int i = 0; i < 600; i++) begin
      bit v;
      bit clr;
      bit ld;
      int d;
      v   = ($urandom % 4) != 0;
      d   = (($urandom % 8) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 3));
      clr = ($urandom % 30) == 0;
      ld  = ($urandom % 20) == 0;
      rc  = '0;
      for (int k = 0; k < ND; k++) rc = rc | (16'($urandom_range(1, 3)) << (DW * k));
      step(v, d, clr, ld, rc);
    end
    idle(2);

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
